rr_arbiter: RTL
===============

# rr_arbiter

Parametrised N-way round-robin arbiter, the successor to the fixed 4-client priority arbiter. It grants one of `N` requesters a registered one-hot grant and holds it while the owner keeps requesting. Priority rotates so no requester starves. Ownership hands off directly to the next requester with no idle bubble. An optional hold limit forces rotation away from a requester that holds the grant too long.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per ownership; ≥1; used only with `ARB_HOLD_LIMIT_EN`.
- `clk  input  1`: clock; all state updates on the rising edge.
- `n_rst  input  1`: reset, asynchronous and active-low.
- `req  input  N`: request vector; `req[i]` high means requester i wants the resource.
- `gnt  output  N`: registered one-hot grant; all-zero when idle.
- `gnt_valid  output  1`: registered; high whenever any `gnt` bit is high.
- `gnt_id  output  $clog2(N)`: registered binary index of the current owner; 0 when idle.

## Operation
- Two states:
  - IDLE: no grant.
  - GRANT: one owner holds the grant.
- Rotating pointer `ptr` (`$clog2(N)` bits) names the highest-priority index.
  - Search order: `ptr`, `ptr+1`, …, `N-1`, 0, …, `ptr-1`, all mod N.
- IDLE → GRANT: any `req` bit high. Grant the first set bit in search order; set `ptr` = winner+1 mod N (wraps at N-1 → 0).
- GRANT, owner `req[i]` still high: hold `gnt`, `gnt_id` and `ptr` unchanged (subject to the hold limit).
- GRANT, owner `req[i]` low: re-arbitrate in the same cycle over `req` with bit i excluded.
  - Winner found → GRANT to the winner with no idle cycle; update `ptr`.
  - No winner → IDLE; outputs go to zero.
- A requester that has just been granted cannot win again until every other pending requester has had a turn.
- Non-owner `req` bits may toggle freely; they have no effect until the next arbitration.
- `gnt` is always one-hot or zero. `gnt_id` and `gnt` always agree.
- Reset values:
  - `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0.
  - `ptr` = 0, state = IDLE, hold counter = 0.
  - After reset, index 0 has the highest priority.

## Timing
- Latency is 1 cycle: `req` sampled at edge k is reflected in `gnt` after edge k.
- Release is also 1 cycle: owner drops `req` before edge k → new owner's `gnt` (or all-zero) after edge k. Old and new grants never overlap.
- Simultaneous owner release and new requests: the new requests are arbitrated at that same edge.
- Reset mid-grant: outputs clear immediately, asynchronously. The first grant after reset is evaluated with `ptr` = 0.
- No combinational path from `req` to any output.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined:
  - A hold counter counts cycles in the current ownership. It loads 1 on each new grant, increments while held, and saturates at `MAX_HOLD`.
  - When the counter equals `MAX_HOLD` and any other `req` bit is high, force re-arbitration with the owner excluded, even if the owner's `req` is still high. The owner's `gnt` is therefore high for exactly `MAX_HOLD` cycles.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- `ARB_HOLD_LIMIT_EN` undefined:
  - No counter; `MAX_HOLD` is ignored.
  - The owner holds the grant indefinitely while `req[i]` stays high.

## Test plan
- Reset: assert `n_rst` low with `req` = 4'b1111 → `gnt` = 0, `gnt_valid` = 0, `gnt_id` = 0 throughout. After release, `gnt` = 4'b0001 one cycle later.
- Single requester: `req` = 4'b0100 from IDLE → `gnt` = 4'b0100, `gnt_id` = 2 after one edge. Drop `req` → `gnt` = 0 one edge later.
- Round-robin fairness: `req` = 4'b1111 held, each owner drops its bit for one cycle after holding 2 cycles → grant order 0, 1, 2, 3, 0 with no idle cycles between owners.
- Wrap and fairness: grant index 3 (`ptr` → 0), then `req` = 4'b1001, owner 3 releases → `gnt` = 4'b0001. Owner 0 releases with `req[3]` still high → `gnt` = 4'b1000.
- Hold limit (with macro, `MAX_HOLD` = 8): `req[0]` held high, `req[1]` raised at cycle 3 → `gnt[0]` high exactly 8 cycles, then `gnt` = 4'b0010. Without the macro → `gnt[0]` stays high indefinitely.
- Reset mid-operation: pulse `n_rst` low while `gnt` = 4'b0100 → outputs clear immediately. With `req` = 4'b0110 after reset → `gnt` = 4'b0010.

Source files
------------

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with registered one-hot grant and direct owner hand-off.
// Optional hold limit via `ARB_HOLD_LIMIT_EN (MAX_HOLD cycles per ownership). Rev 1.0
`default_nettype none

module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic [N-1:0]           req,
   output logic [N-1:0]           gnt,
   output logic                   gnt_valid,
   output logic [$clog2(N)-1:0]   gnt_id
);

   localparam int W = $clog2(N);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   generate
      if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
         $error("rr_arbiter: N must be 2..16 and MAX_HOLD >= 1");
      end
   endgenerate

   state_t         state, state_nx;
   logic [W-1:0]   ptr, ptr_nx;
   logic [N-1:0]   gnt_nx;
   logic [W-1:0]   id_nx;
   logic           valid_nx;

   logic [N-1:0]   cand;
   logic           win_found;
   logic [W-1:0]   win_idx;
   logic           owner_req;
   logic           release_own;
   logic           arb;

   // The owner is masked out so a re-arbitration always moves the grant on.
   always_comb begin
      cand      = req & ~gnt;
      win_found = 1'b0;
      win_idx   = '0;
      for (int off = 0; off < N; off++) begin
         int i;
         i = int'(ptr) + off;
         if (i >= N) i = i - N;
         if (!win_found && cand[i]) begin
            win_found = 1'b1;
            win_idx   = W'(i);
         end
      end
   end

   assign owner_req = |(req & gnt);

`ifdef ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);
   logic [HW-1:0] hold_cnt, hold_nx;
   logic          hold_hit;

   assign hold_hit    = (hold_cnt == HW'(MAX_HOLD)) && (|cand);
   assign release_own = !owner_req || hold_hit;

   always_comb begin
      hold_nx = hold_cnt;
      if (arb && win_found)
         hold_nx = HW'(1);
      else if (state_nx == IDLE)
         hold_nx = '0;
      else if (hold_cnt != HW'(MAX_HOLD))
         hold_nx = hold_cnt + HW'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) hold_cnt <= '0;
      else        hold_cnt <= hold_nx;
   end
`else
   assign release_own = !owner_req;
`endif

   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      id_nx    = gnt_id;
      ptr_nx   = ptr;
      arb      = 1'b0;
      case (state)
         IDLE:    arb = 1'b1;
         GRANT:   arb = release_own;
         default: arb = 1'b1;
      endcase
      if (arb) begin
         if (win_found) begin
            state_nx        = GRANT;
            gnt_nx          = '0;
            gnt_nx[win_idx] = 1'b1;
            id_nx           = win_idx;
            ptr_nx          = (win_idx == W'(N - 1)) ? '0 : win_idx + W'(1);
         end else begin
            state_nx = IDLE;
            gnt_nx   = '0;
            id_nx    = '0;
         end
      end
      valid_nx = (state_nx == GRANT);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state     <= IDLE;
         ptr       <= '0;
         gnt       <= '0;
         gnt_id    <= '0;
         gnt_valid <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         gnt       <= gnt_nx;
         gnt_id    <= id_nx;
         gnt_valid <= valid_nx;
      end
   end

endmodule

`default_nettype wire
